system: RTL and testbench

SYSTEM -- requirements
Module: system

---
 rtl/system_pkg.sv | 36 +++
 rtl/system_data_memory.sv | 41 ++++
 rtl/system.sv | 90 +++++++++
 tb/tb_system.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/system_pkg.sv
// Shared constants for the single-cycle 8-bit core: opcodes, instruction
// field positions and the data-memory stall length.
package system_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int RD_HI  = 23;
  localparam int RD_LO  = 16;
  localparam int RS1_HI = 15;
  localparam int RS1_LO = 8;
  localparam int RS2_HI = 7;
  localparam int RS2_LO = 0;

  localparam logic [2:0] MEM_STALL_CYCLES = 3'd4;

  typedef enum logic [7:0] {
    OP_ADD   = 8'd0,
    OP_SUB   = 8'd1,
    OP_AND   = 8'd2,
    OP_OR    = 8'd3,
    OP_J     = 8'd4,
    OP_BEQ   = 8'd5,
    OP_MOV   = 8'd6,
    OP_LOADI = 8'd7,
    OP_BNE   = 8'd8,
    OP_SLL   = 8'd9,
    OP_SRL   = 8'd10,
    OP_SRA   = 8'd11,
    OP_ROR   = 8'd12,
    OP_LWD   = 8'd13,
    OP_LWI   = 8'd14,
    OP_SWD   = 8'd15,
    OP_SWI   = 8'd16
  } opcode_e;

endpackage

// File: rtl/system_data_memory.sv
// 256 x 8 data memory; every access stalls for MEM_STALL_CYCLES cycles and
// commits on the following edge.
module data_memory
  import system_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic [7:0] address_i,
  input  logic [7:0] writedata_i,
  output logic [7:0] readdata_o,
  output logic       busywait_o
);

  logic [7:0] mem_q [256];
  logic [2:0] cnt_q;
  logic       access;

  assign access     = read_i | write_i;
  assign busywait_o = access && (cnt_q != MEM_STALL_CYCLES);
  assign readdata_o = mem_q[address_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
    end else if (access) begin
      // counter rearms on the commit edge so back-to-back accesses each stall
      if (cnt_q == MEM_STALL_CYCLES) begin
        cnt_q <= '0;
        if (write_i) mem_q[address_i] <= writedata_i;
      end else begin
        cnt_q <= cnt_q + 3'd1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/system.sv
// Single-cycle 8-bit core with 32-bit PC; register file and control live here,
// loads/stores go through the stalling data_memory.
module system
  import system_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] PC
);

  logic [31:0] pc_q, pc_d, pc_plus4, br_target;
  logic [7:0]  regs_q [8];
  opcode_e     opcode;
  logic [7:0]  imm, off, rs1_val, rs2_val;
  logic [2:0]  rd_idx, rs1_idx, rs2_idx;
  logic        reg_we, mem_read, mem_write, mem_busy;
  logic [7:0]  reg_wdata, mem_addr, mem_rdata;
  logic [15:0] ror_dbl;
  logic signed [7:0] sra_val;
  logic [4:0]  unused_rs1_hi;

  assign opcode        = opcode_e'(INSTRUCTION[OPC_HI:OPC_LO]);
  assign off           = INSTRUCTION[RD_HI:RD_LO];
  assign imm           = INSTRUCTION[RS2_HI:RS2_LO];
  assign rd_idx        = INSTRUCTION[RD_LO+2:RD_LO];
  assign rs1_idx       = INSTRUCTION[RS1_LO+2:RS1_LO];
  assign rs2_idx       = INSTRUCTION[RS2_LO+2:RS2_LO];
  assign unused_rs1_hi = INSTRUCTION[RS1_HI:RS1_LO+3];

  assign rs1_val   = regs_q[rs1_idx];
  assign rs2_val   = regs_q[rs2_idx];
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{22{off[7]}}, off, 2'b00};
  assign ror_dbl   = {rs1_val, rs1_val} >> imm[2:0];
  assign sra_val   = $signed(rs1_val) >>> imm[2:0];
  assign PC        = pc_q;

  always_comb begin
    pc_d      = pc_plus4;
    reg_we    = 1'b0;
    reg_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = imm;
    case (opcode)
      OP_ADD:   begin reg_we = 1'b1; reg_wdata = rs1_val + rs2_val; end
      OP_SUB:   begin reg_we = 1'b1; reg_wdata = rs1_val + (~rs2_val + 8'd1); end
      OP_AND:   begin reg_we = 1'b1; reg_wdata = rs1_val & rs2_val; end
      OP_OR:    begin reg_we = 1'b1; reg_wdata = rs1_val | rs2_val; end
      OP_J:     pc_d = br_target;
      OP_BEQ:   if (rs1_val == rs2_val) pc_d = br_target;
      OP_BNE:   if (rs1_val != rs2_val) pc_d = br_target;
      OP_MOV:   begin reg_we = 1'b1; reg_wdata = rs2_val; end
      OP_LOADI: begin reg_we = 1'b1; reg_wdata = imm; end
      OP_SLL:   begin reg_we = 1'b1; reg_wdata = (|imm[7:3]) ? 8'h00 : rs1_val << imm[2:0]; end
      OP_SRL:   begin reg_we = 1'b1; reg_wdata = (|imm[7:3]) ? 8'h00 : rs1_val >> imm[2:0]; end
      OP_SRA:   begin reg_we = 1'b1; reg_wdata = (|imm[7:3]) ? {8{rs1_val[7]}} : sra_val; end
      OP_ROR:   begin reg_we = 1'b1; reg_wdata = ror_dbl[7:0]; end
      OP_LWD:   begin mem_read = 1'b1; mem_addr = rs2_val; reg_we = 1'b1; reg_wdata = mem_rdata; end
      OP_LWI:   begin mem_read = 1'b1; reg_we = 1'b1; reg_wdata = mem_rdata; end
      OP_SWD:   begin mem_write = 1'b1; mem_addr = rs2_val; end
      OP_SWI:   mem_write = 1'b1;
      default:  ;
    endcase
  end

  // a pending memory access freezes both PC and the register file
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= '0;
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (!mem_busy) begin
      pc_q <= pc_d;
      if (reg_we) regs_q[rd_idx] <= reg_wdata;
    end
  end

  data_memory u_mem (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .read_i      (mem_read),
    .write_i     (mem_write),
    .address_i   (mem_addr),
    .writedata_i (rs1_val),
    .readdata_o  (mem_rdata),
    .busywait_o  (mem_busy)
  );

endmodule

// File: tb/tb_system.sv
// Directed bench for the system core: programs are fed one word at a time and
// register/memory state is checked against hand-computed values.
module tb_system;
  import system_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC;
  int n_cmp  = 0;
  int n_fail = 0;

  system dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] ins);
    INSTRUCTION = ins;
    @(posedge CLK); #1;
  endtask

  task automatic mem_step(input string tag, input logic [31:0] ins, input logic [31:0] pc0);
    INSTRUCTION = ins;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      chk({tag, "_hold"}, PC, pc0);
    end
    @(posedge CLK); #1;
    chk({tag, "_adv"}, PC, pc0 + 32'd4);
  endtask

  initial begin
    RESET = 1'b1;
    INSTRUCTION = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", PC, 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_reg", {24'd0, dut.regs_q[i]}, 32'd0);
    RESET = 1'b0;

    step(enc(OP_LOADI, 8'd3, 8'd0, 8'd15));
    step(enc(OP_LOADI, 8'd4, 8'd0, 8'd12));
    step(enc(OP_LOADI, 8'd5, 8'd0, 8'd1));
    chk("ldi_r3", {24'd0, dut.regs_q[3]}, 32'h0F);
    chk("ldi_r4", {24'd0, dut.regs_q[4]}, 32'h0C);
    chk("ldi_r5", {24'd0, dut.regs_q[5]}, 32'h01);
    chk("ldi_pc", PC, 32'd12);

    mem_step("swi1", enc(OP_SWI, 8'd0, 8'd4, 8'h01), 32'd12);
    chk("mem1", {24'd0, dut.u_mem.mem_q[1]}, 32'd12);
    mem_step("swi2", enc(OP_SWI, 8'd0, 8'd5, 8'h02), 32'd16);
    chk("mem2", {24'd0, dut.u_mem.mem_q[2]}, 32'd1);
    mem_step("lwd", enc(OP_LWD, 8'd1, 8'd0, 8'd5), 32'd20);
    chk("lwd_r1", {24'd0, dut.regs_q[1]}, 32'd12);
    mem_step("lwi", enc(OP_LWI, 8'd2, 8'd0, 8'h02), 32'd24);
    chk("lwi_r2", {24'd0, dut.regs_q[2]}, 32'd1);
    mem_step("swd", enc(OP_SWD, 8'd0, 8'd4, 8'd4), 32'd28);
    chk("mem12", {24'd0, dut.u_mem.mem_q[12]}, 32'd12);
    mem_step("lwi6", enc(OP_LWI, 8'd6, 8'd0, 8'h0C), 32'd32);
    chk("lwi_r6", {24'd0, dut.regs_q[6]}, 32'd12);

    step(enc(OP_LOADI, 8'd1, 8'd0, 8'h05));
    step(enc(OP_LOADI, 8'd2, 8'd0, 8'h07));
    step(enc(OP_SUB, 8'd0, 8'd1, 8'd2));
    chk("sub", {24'd0, dut.regs_q[0]}, 32'hFE);
    step(enc(OP_AND, 8'd0, 8'd1, 8'd2));
    chk("and", {24'd0, dut.regs_q[0]}, 32'h05);
    step(enc(OP_OR, 8'd0, 8'd1, 8'd2));
    chk("or", {24'd0, dut.regs_q[0]}, 32'h07);
    step(enc(OP_LOADI, 8'd1, 8'd0, 8'hFF));
    step(enc(OP_LOADI, 8'd2, 8'd0, 8'h02));
    step(enc(OP_ADD, 8'd0, 8'd1, 8'd2));
    chk("add_wrap", {24'd0, dut.regs_q[0]}, 32'h01);
    chk("alu_pc", PC, 32'd68);

    step(enc(OP_LOADI, 8'd7, 8'd0, 8'h81));
    step(enc(OP_SLL, 8'd0, 8'd7, 8'd1));
    chk("sll1", {24'd0, dut.regs_q[0]}, 32'h02);
    step(enc(OP_SRL, 8'd0, 8'd7, 8'd1));
    chk("srl1", {24'd0, dut.regs_q[0]}, 32'h40);
    step(enc(OP_SRA, 8'd0, 8'd7, 8'd1));
    chk("sra1", {24'd0, dut.regs_q[0]}, 32'hC0);
    step(enc(OP_ROR, 8'd0, 8'd7, 8'd1));
    chk("ror1", {24'd0, dut.regs_q[0]}, 32'hC0);
    step(enc(OP_SLL, 8'd0, 8'd7, 8'd8));
    chk("sll8", {24'd0, dut.regs_q[0]}, 32'h00);
    step(enc(OP_SRA, 8'd0, 8'd7, 8'd8));
    chk("sra8", {24'd0, dut.regs_q[0]}, 32'hFF);
    step(enc(OP_MOV, 8'd3, 8'd0, 8'd5));
    chk("mov", {24'd0, dut.regs_q[3]}, 32'h01);
    step(enc(8'hFF, 8'd0, 8'd0, 8'd0));
    chk("nop_r0", {24'd0, dut.regs_q[0]}, 32'hFF);
    chk("nop_pc", PC, 32'd104);

    step(enc(OP_J, 8'hE9, 8'd0, 8'd0));
    chk("j_fwd16", PC, 32'd16);
    step(enc(OP_J, 8'hFE, 8'd0, 8'd0));
    chk("j_m2", PC, 32'd12);
    step(enc(OP_LOADI, 8'd1, 8'd0, 8'd9));
    step(enc(OP_LOADI, 8'd2, 8'd0, 8'd9));
    step(enc(OP_BEQ, 8'd3, 8'd1, 8'd2));
    chk("beq_taken", PC, 32'd36);
    step(enc(OP_BNE, 8'd5, 8'd1, 8'd2));
    chk("bne_not", PC, 32'd40);
    step(enc(OP_LOADI, 8'd2, 8'd0, 8'd8));
    step(enc(OP_BNE, 8'd1, 8'd1, 8'd2));
    chk("bne_taken", PC, 32'd52);
    step(enc(OP_BEQ, 8'd1, 8'd1, 8'd2));
    chk("beq_not", PC, 32'd56);
    step(enc(OP_J, 8'hF0, 8'd0, 8'd0));
    chk("j_neg", PC, 32'hFFFF_FFFC);
    step(enc(OP_LOADI, 8'd5, 8'd0, 8'd7));
    chk("pc_wrap", PC, 32'd0);

    INSTRUCTION = enc(OP_SWI, 8'd0, 8'd4, 8'h30);
    @(posedge CLK); #1;
    chk("rst_stall_hold", PC, 32'd0);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    INSTRUCTION = enc(OP_LOADI, 8'd1, 8'd0, 8'd3);
    chk("rst_mid_pc", PC, 32'd0);
    chk("rst_mid_mem30", {24'd0, dut.u_mem.mem_q[8'h30]}, 32'd0);
    chk("rst_mid_mem1", {24'd0, dut.u_mem.mem_q[1]}, 32'd0);
    for (int i = 0; i < 8; i++) chk("rst_mid_reg", {24'd0, dut.regs_q[i]}, 32'd0);
    @(posedge CLK); #1;
    chk("post_rst_pc", PC, 32'd4);
    chk("post_rst_r1", {24'd0, dut.regs_q[1]}, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
